// File: rtl/store_coalesce_buffer_pkg.sv
// Shared types and helpers for the write-combining store buffer.
// Holds the access-size encoding and the size-to-byte-mask helper
// used by both the store path and the load-forwarding path.
package stb_pkg;

  // Access size encoding shared by stores and loads.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // LSB-aligned byte-enable mask for an access of the given size.
  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size_e'(size))
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_to_align(input logic [1:0] size);
    logic [2:0] a;
    case (size_e'(size))
      SZ_B:    a = 3'b000;
      SZ_H:    a = 3'b001;
      SZ_W:    a = 3'b011;
      default: a = 3'b111;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/store_coalesce_buffer_fwd_sel.sv
// Per-byte youngest-first forwarding select across buffer entries.
// Purely combinational; no latency, no backpressure.
// Ports: match/mask/data are age-ordered (index 0 = oldest = head);
//        byte_data/found give the winning byte and a hit flag per line byte.
module stb_fwd_sel
  import stb_pkg::*;
#(
  parameter int N_ENTRIES  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic [N_ENTRIES-1:0]                   match,
  input  logic [N_ENTRIES-1:0][LINE_BYTES-1:0]   mask,
  input  logic [N_ENTRIES-1:0][LINE_BYTES*8-1:0] data,
  output logic [LINE_BYTES-1:0][7:0]             byte_data,
  output logic [LINE_BYTES-1:0]                  found
);

  // Walking oldest to youngest and overwriting lets the youngest writer win.
  always_comb begin
    byte_data = '0;
    found     = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (match[k] && mask[k][b]) begin
          found[b]     = 1'b1;
          byte_data[b] = data[k][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_coalesce_buffer.sv
// Write-combining store buffer: coalesces sized stores into line entries,
// forwards to loads (zero latency), drains oldest-first to the L1.
// Stores stall only when full and no merge target exists; head holds while offered.
// Ports: st_* store request/err, ld_* combinational load lookup,
//        cm_* valid/ready commit of the head line, drain/empty/full status.
module store_coalesce_buffer
  import stb_pkg::*;
#(
  parameter int PA_WIDTH     = 32,
  parameter int XLEN         = 64,
  parameter int LINE_BYTES   = 16,
  parameter int N_ENTRIES    = 4,
  parameter int DRAIN_THRESH = N_ENTRIES - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_st_valid,
  output logic                    o_st_ready,
  input  logic [PA_WIDTH-1:0]     i_st_addr,
  input  logic [1:0]              i_st_size,
  input  logic [XLEN-1:0]         i_st_data,
  output logic                    o_st_err,
  input  logic                    i_ld_valid,
  input  logic [PA_WIDTH-1:0]     i_ld_addr,
  input  logic [1:0]              i_ld_size,
  output logic                    o_ld_hit,
  output logic                    o_ld_partial,
  output logic [XLEN-1:0]         o_ld_data,
  output logic                    o_cm_valid,
  input  logic                    i_cm_ready,
  output logic [PA_WIDTH-1:0]     o_cm_addr,
  output logic [LINE_BYTES*8-1:0] o_cm_data,
  output logic [LINE_BYTES-1:0]   o_cm_mask,
  input  logic                    i_drain,
  output logic                    o_empty,
  output logic                    o_full
);

  localparam int   XB     = XLEN / 8;
  localparam int   LW     = LINE_BYTES * 8;
  localparam int   OFF_W  = $clog2(LINE_BYTES);
  localparam int   TAG_W  = PA_WIDTH - OFF_W;
  localparam int   IDX_W  = $clog2(N_ENTRIES);
  localparam int   CNT_W  = IDX_W + 1;
  localparam logic HAS_DW = (XLEN >= 64);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [LW-1:0]         data;
    logic [LINE_BYTES-1:0] mask;
    logic                  valid;
  } entry_t;

  entry_t           ent [N_ENTRIES];
  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             cm_valid;

  // Entry index by age: slot 0 is the head (oldest).
  logic [N_ENTRIES-1:0][IDX_W-1:0] age_idx;
  always_comb begin
    for (int k = 0; k < N_ENTRIES; k++) age_idx[k] = head + IDX_W'(k);
  end

  // ---------------- store path ----------------
  logic [TAG_W-1:0]      st_tag;
  logic [OFF_W-1:0]      st_off;
  logic                  st_bad;
  logic [LINE_BYTES-1:0] st_line_mask;
  logic [LW-1:0]         st_line_data;

  assign st_tag = i_st_addr[PA_WIDTH-1:OFF_W];
  assign st_off = i_st_addr[OFF_W-1:0];

  // Dword is illegal on a 32-bit datapath; otherwise natural alignment only.
  assign st_bad = ((i_st_addr[2:0] & size_to_align(i_st_size)) != 3'b000) ||
                  ((i_st_size == 2'd3) && !HAS_DW);

  assign st_line_mask = LINE_BYTES'(XB'(size_to_mask(i_st_size))) << st_off;
  assign st_line_data = LW'(i_st_data) << {st_off, 3'b000};

  // Youngest valid entry on the same line is the merge candidate.
  logic             mrg_found;
  logic [IDX_W-1:0] mrg_idx;
  always_comb begin
    mrg_found = 1'b0;
    mrg_idx   = head;
    for (int k = 0; k < N_ENTRIES; k++) begin
      if (ent[age_idx[k]].valid && ent[age_idx[k]].tag == st_tag) begin
        mrg_found = 1'b1;
        mrg_idx   = age_idx[k];
      end
    end
  end

  // An offered head is frozen, so a same-line store must open a new entry.
  logic merge_ok;
  assign merge_ok = mrg_found && !(mrg_idx == head && cm_valid);

  logic [LW-1:0] merged_data;
  always_comb begin
    merged_data = ent[mrg_idx].data;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (st_line_mask[b]) merged_data[b*8 +: 8] = st_line_data[b*8 +: 8];
    end
  end

  logic st_fire, do_merge, do_alloc;
  assign o_full     = (count == CNT_W'(N_ENTRIES));
  assign o_empty    = (count == '0);
  assign o_st_ready = merge_ok || !o_full;
  assign st_fire    = i_st_valid && o_st_ready;
  assign o_st_err   = st_fire && st_bad;
  assign do_merge   = st_fire && !st_bad && merge_ok;
  assign do_alloc   = st_fire && !st_bad && !merge_ok;

  // ---------------- commit path ----------------
  logic cm_fire, cm_rise;
  assign cm_fire = cm_valid && i_cm_ready;
  assign cm_rise = !o_empty && ((count >= CNT_W'(DRAIN_THRESH)) || i_drain);

  assign o_cm_valid = cm_valid;
  assign o_cm_addr  = {ent[head].tag, {OFF_W{1'b0}}};
  assign o_cm_data  = ent[head].data;
  assign o_cm_mask  = ent[head].mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) ent[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      cm_valid <= 1'b0;
    end else begin
      if (cm_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].mask  <= '0;
        head            <= head + 1'b1;
      end
      // Alloc never targets the head while it is committing: tail == head
      // only when empty (nothing offered) or full (no alloc).
      if (do_alloc) begin
        ent[tail].tag   <= st_tag;
        ent[tail].data  <= st_line_data;
        ent[tail].mask  <= st_line_mask;
        ent[tail].valid <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (do_merge) begin
        ent[mrg_idx].data <= merged_data;
        ent[mrg_idx].mask <= ent[mrg_idx].mask | st_line_mask;
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(cm_fire);
      // Offer is held until accepted; a fresh offer is re-evaluated afterwards.
      cm_valid <= cm_valid ? !i_cm_ready : cm_rise;
    end
  end

  // ---------------- load forwarding ----------------
  logic [TAG_W-1:0]                    ld_tag;
  logic [OFF_W-1:0]                    ld_off;
  logic [N_ENTRIES-1:0]                fw_match;
  logic [N_ENTRIES-1:0][LINE_BYTES-1:0] fw_mask;
  logic [N_ENTRIES-1:0][LW-1:0]        fw_data;
  logic [LINE_BYTES-1:0][7:0]          line_byte;
  logic [LINE_BYTES-1:0]               line_found;

  assign ld_tag = i_ld_addr[PA_WIDTH-1:OFF_W];
  assign ld_off = i_ld_addr[OFF_W-1:0];

  always_comb begin
    for (int k = 0; k < N_ENTRIES; k++) begin
      fw_match[k] = ent[age_idx[k]].valid && (ent[age_idx[k]].tag == ld_tag);
      fw_mask[k]  = ent[age_idx[k]].mask;
      fw_data[k]  = ent[age_idx[k]].data;
    end
  end

  stb_fwd_sel #(
    .N_ENTRIES (N_ENTRIES),
    .LINE_BYTES(LINE_BYTES)
  ) u_fwd_sel (
    .match    (fw_match),
    .mask     (fw_mask),
    .data     (fw_data),
    .byte_data(line_byte),
    .found    (line_found)
  );

  // Loads are assumed aligned, so offset + j stays inside the line.
  logic [XB-1:0] ld_req, ld_got;
  always_comb begin
    ld_req    = XB'(size_to_mask(i_ld_size));
    ld_got    = '0;
    o_ld_data = '0;
    for (int j = 0; j < XB; j++) begin
      if (i_ld_valid && ld_req[j] && line_found[OFF_W'(32'(ld_off) + j)]) begin
        ld_got[j]          = 1'b1;
        o_ld_data[j*8 +: 8] = line_byte[OFF_W'(32'(ld_off) + j)];
      end
    end
  end

  assign o_ld_hit     = i_ld_valid && (ld_got == ld_req);
  assign o_ld_partial = i_ld_valid && (ld_got != '0) && (ld_got != ld_req);

endmodule

// File: tb/tb_store_coalesce_buffer.sv
module tb_store_coalesce_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_st_valid, o_st_ready, o_st_err;
  logic [31:0]  i_st_addr;
  logic [1:0]   i_st_size;
  logic [63:0]  i_st_data;
  logic         i_ld_valid, o_ld_hit, o_ld_partial;
  logic [31:0]  i_ld_addr;
  logic [1:0]   i_ld_size;
  logic [63:0]  o_ld_data;
  logic         o_cm_valid, i_cm_ready;
  logic [31:0]  o_cm_addr;
  logic [127:0] o_cm_data;
  logic [15:0]  o_cm_mask;
  logic         i_drain, o_empty, o_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_coalesce_buffer dut (
    .clk(clk), .rst(rst),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_addr(i_st_addr),
    .i_st_size(i_st_size), .i_st_data(i_st_data), .o_st_err(o_st_err),
    .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_size(i_ld_size),
    .o_ld_hit(o_ld_hit), .o_ld_partial(o_ld_partial), .o_ld_data(o_ld_data),
    .o_cm_valid(o_cm_valid), .i_cm_ready(i_cm_ready), .o_cm_addr(o_cm_addr),
    .o_cm_data(o_cm_data), .o_cm_mask(o_cm_mask), .i_drain(i_drain),
    .o_empty(o_empty), .o_full(o_full)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    i_st_valid = 1'b1; i_st_addr = a; i_st_size = s; i_st_data = d;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] s);
    i_ld_valid = 1'b1; i_ld_addr = a; i_ld_size = s;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    i_st_valid = 1'b0; i_st_addr = '0; i_st_size = '0; i_st_data = '0;
    i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_size = '0;
    i_cm_ready = 1'b0; i_drain = 1'b0;
    #3;
    chk("rst_empty",    128'(o_empty),      128'd1);
    chk("rst_st_ready", 128'(o_st_ready),   128'd1);
    chk("rst_full",     128'(o_full),       128'd0);
    chk("rst_cm_valid", 128'(o_cm_valid),   128'd0);
    chk("rst_st_err",   128'(o_st_err),     128'd0);
    chk("rst_ld_hit",   128'(o_ld_hit),     128'd0);
    chk("rst_ld_part",  128'(o_ld_partial), 128'd0);
    chk("rst_cm_addr",  128'(o_cm_addr),    128'd0);
    chk("rst_cm_mask",  128'(o_cm_mask),    128'd0);
    go();
    rst = 1'b0;

    // Store word, then load it back the next cycle.
    st(32'h1004, 2'd2, 64'hDEADBEEF);
    #1 chk("t1_st_ready", 128'(o_st_ready), 128'd1);
    chk("t1_st_err", 128'(o_st_err), 128'd0);
    go();
    i_st_valid = 1'b0;
    ld(32'h1004, 2'd2);
    #1 chk("t1_ld_hit", 128'(o_ld_hit), 128'd1);
    chk("t1_ld_part", 128'(o_ld_partial), 128'd0);
    chk("t1_ld_data", 128'(o_ld_data), 128'hDEADBEEF);
    chk("t1_empty", 128'(o_empty), 128'd0);
    chk("t1_cm_valid", 128'(o_cm_valid), 128'd0);
    go();

    // Byte store, half load covering one present and one absent byte.
    i_ld_valid = 1'b0;
    st(32'h2001, 2'd0, 64'hAA);
    go();
    i_st_valid = 1'b0;
    ld(32'h2000, 2'd1);
    #1 chk("t2_ld_part", 128'(o_ld_partial), 128'd1);
    chk("t2_ld_hit", 128'(o_ld_hit), 128'd0);
    chk("t2_ld_data", 128'(o_ld_data), 128'hAA00);
    go();

    // Drain both entries in order.
    i_ld_valid = 1'b0;
    i_drain = 1'b1; i_cm_ready = 1'b1;
    go();
    chk("d0_cm_valid", 128'(o_cm_valid), 128'd1);
    chk("d0_cm_addr", 128'(o_cm_addr), 128'h1000);
    chk("d0_cm_mask", 128'(o_cm_mask), 128'h00F0);
    chk("d0_cm_data", o_cm_data, 128'h00000000_00000000_DEADBEEF_00000000);
    go();
    go();
    chk("d1_cm_valid", 128'(o_cm_valid), 128'd1);
    chk("d1_cm_addr", 128'(o_cm_addr), 128'h2000);
    chk("d1_cm_mask", 128'(o_cm_mask), 128'h0002);
    go();
    chk("d_empty", 128'(o_empty), 128'd1);
    i_drain = 1'b0; i_cm_ready = 1'b0;
    go();

    // Two stores on one line coalesce into a single entry.
    st(32'h3000, 2'd0, 64'h11);
    go();
    st(32'h3008, 2'd3, 64'h0123456789ABCDEF);
    #1 chk("t3_st_ready", 128'(o_st_ready), 128'd1);
    go();
    i_st_valid = 1'b0;
    ld(32'h3008, 2'd3);
    #1 chk("t3_ld_hit", 128'(o_ld_hit), 128'd1);
    chk("t3_ld_data", 128'(o_ld_data), 128'h0123456789ABCDEF);
    i_ld_valid = 1'b0;
    i_drain = 1'b1;
    go();
    chk("t3_cm_valid", 128'(o_cm_valid), 128'd1);
    chk("t3_cm_addr", 128'(o_cm_addr), 128'h3000);
    chk("t3_cm_mask", 128'(o_cm_mask), 128'hFF01);
    chk("t3_cm_data", o_cm_data, 128'h0123456789ABCDEF_0000000000000011);

    // Head is offered and held: a same-line store opens a new entry.
    st(32'h3008, 2'd2, 64'hCAFEF00D);
    #1 chk("t4_st_ready", 128'(o_st_ready), 128'd1);
    go();
    i_st_valid = 1'b0;
    ld(32'h3008, 2'd3);
    #1 chk("t4_cm_data", o_cm_data, 128'h0123456789ABCDEF_0000000000000011);
    chk("t4_cm_mask", 128'(o_cm_mask), 128'hFF01);
    chk("t4_ld_hit", 128'(o_ld_hit), 128'd1);
    chk("t4_ld_data", 128'(o_ld_data), 128'h01234567CAFEF00D);
    ld(32'h3000, 2'd3);
    #1 chk("t4_ld_part", 128'(o_ld_partial), 128'd1);
    chk("t4_ld_data0", 128'(o_ld_data), 128'h11);
    chk("t4_full", 128'(o_full), 128'd0);
    i_ld_valid = 1'b0;

    // Fill remaining slots with distinct lines.
    st(32'h5000, 2'd0, 64'h55);
    go();
    st(32'h6000, 2'd0, 64'h66);
    go();
    st(32'h7000, 2'd0, 64'h77);
    i_cm_ready = 1'b1; i_drain = 1'b0;
    #1 chk("t5_full", 128'(o_full), 128'd1);
    chk("t5_st_ready", 128'(o_st_ready), 128'd0);
    chk("t5_cm_valid", 128'(o_cm_valid), 128'd1);
    go();
    i_st_valid = 1'b0; i_cm_ready = 1'b0;
    ld(32'h7000, 2'd0);
    #1 chk("t5_full_after", 128'(o_full), 128'd0);
    chk("t5_empty_after", 128'(o_empty), 128'd0);
    chk("t5_no_accept_hit", 128'(o_ld_hit), 128'd0);
    chk("t5_no_accept_part", 128'(o_ld_partial), 128'd0);
    ld(32'h5000, 2'd0);
    #1 chk("t5_ld_hit", 128'(o_ld_hit), 128'd1);
    chk("t5_ld_data", 128'(o_ld_data), 128'h55);
    i_ld_valid = 1'b0;
    go();
    // Occupancy 3 reaches the threshold; the wrapped head is offered without drain.
    chk("t5_thr_valid", 128'(o_cm_valid), 128'd1);
    chk("t5_thr_addr", 128'(o_cm_addr), 128'h3000);
    chk("t5_thr_mask", 128'(o_cm_mask), 128'h0F00);
    chk("t5_thr_data", o_cm_data, 128'h00000000_CAFEF00D_00000000_00000000);

    // Misaligned half: error pulse, handshaken, buffer untouched.
    st(32'h4001, 2'd1, 64'hBEEF);
    #1 chk("t6_st_err", 128'(o_st_err), 128'd1);
    chk("t6_st_ready", 128'(o_st_ready), 128'd1);
    go();
    i_st_valid = 1'b0;
    ld(32'h4000, 2'd1);
    #1 chk("t6_err_drop", 128'(o_st_err), 128'd0);
    chk("t6_full", 128'(o_full), 128'd0);
    chk("t6_ld_hit", 128'(o_ld_hit), 128'd0);
    chk("t6_ld_part", 128'(o_ld_partial), 128'd0);
    i_ld_valid = 1'b0;

    // Asynchronous reset while the head is being offered.
    i_cm_ready = 1'b1;
    rst = 1'b1;
    #1 chk("t7_cm_valid", 128'(o_cm_valid), 128'd0);
    chk("t7_empty", 128'(o_empty), 128'd1);
    chk("t7_cm_mask", 128'(o_cm_mask), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
